mem_port_arbiter: RTL and testbench

- Shares the single CPU-side RAM port between CPU load/store requests and the UART loader write stream (addr/data/valid pulses from the UART RAM bridge).
- Loader pulses cannot be back-pressured, so they are buffered in a small FIFO.
- CPU requests have priority, subject to a starvation limit that guarantees loader progress.
- Registered outputs drive the RAM port address, write-data and byte-enables.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between CPU requests and the UART loader write stream.
// Loader pulses are queued in a small FIFO; the CPU wins ties unless the loader is starved.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [3:0]  RANGE_TAG    = 4'h2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [31:0]           ld_addr_in,
  input  logic [31:0]           ld_data_in,
  input  logic                  ld_valid_in,
  input  logic                  cpu_req_in,
  input  logic [31:0]           cpu_addr_in,
  input  logic [31:0]           cpu_data_in,
  input  logic [3:0]            cpu_we_in,
  output logic                  cpu_stall_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [31:0]           mem_data_out,
  output logic [3:0]            mem_we_out,
  output logic                  ld_busy_out,
  output logic                  ld_overflow_out
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [StvW-1:0] StvMax  = StvW'(STARVE_LIMIT);

  logic [31:0]           r_fifo_addr [FIFO_DEPTH];
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic [StvW-1:0]       r_starve_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_data;
  logic [3:0]            r_mem_we;
  logic                  r_busy;
  logic                  r_overflow;

  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_ld_grant;
  logic                  w_cpu_grant;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_range_ok;
  logic [CntW-1:0]       w_count_d;
  logic [StvW-1:0]       w_starve_d;

  always_comb begin
    w_fifo_empty = (r_count == '0);
    w_fifo_full  = (r_count == FullCnt);
    w_ld_grant   = ~w_fifo_empty & (~cpu_req_in | (r_starve_cnt == StvMax));
    w_cpu_grant  = cpu_req_in & ~w_ld_grant;
    // A full FIFO still accepts a pulse when the head drains in the same cycle.
    w_push       = ld_valid_in & (~w_fifo_full | w_ld_grant);
    w_drop       = ld_valid_in & w_fifo_full & ~w_ld_grant;
    w_range_ok   = (cpu_addr_in[19:16] == RANGE_TAG);
    w_count_d    = r_count + CntW'(w_push) - CntW'(w_ld_grant);

    w_starve_d = r_starve_cnt;
    if (w_ld_grant || w_fifo_empty) begin
      w_starve_d = '0;
    end else if (w_cpu_grant && (r_starve_cnt != StvMax)) begin
      w_starve_d = r_starve_cnt + StvW'(1);
    end
  end

  assign cpu_stall_out = cpu_req_in & ~w_cpu_grant;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ld_addr_in;
      r_fifo_data[r_wr_ptr] <= ld_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_we     <= '0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_ld_grant) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count      <= w_count_d;
      r_starve_cnt <= w_starve_d;
      r_busy       <= (w_count_d != '0) | w_ld_grant;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (w_ld_grant) begin
        r_mem_addr <= r_fifo_addr[r_rd_ptr][ADDR_WIDTH+1:2];
        r_mem_data <= r_fifo_data[r_rd_ptr];
        r_mem_we   <= 4'b1111;
      end else if (w_cpu_grant) begin
        r_mem_addr <= cpu_addr_in[ADDR_WIDTH+1:2];
        r_mem_data <= cpu_data_in;
        r_mem_we   <= w_range_ok ? cpu_we_in : 4'b0000;
      end else begin
        r_mem_we <= 4'b0000;
      end
    end
  end

  assign mem_addr_out    = r_mem_addr;
  assign mem_data_out    = r_mem_data;
  assign mem_we_out      = r_mem_we;
  assign ld_busy_out     = r_busy;
  assign ld_overflow_out = r_overflow;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations for loader queueing,
// CPU priority, starvation relief, range masking, overflow and asynchronous reset.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] ld_addr_in;
  logic [31:0] ld_data_in;
  logic        ld_valid_in;
  logic        cpu_req_in;
  logic [31:0] cpu_addr_in;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_we_in;
  logic        cpu_stall_out;
  logic [11:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_we_out;
  logic        ld_busy_out;
  logic        ld_overflow_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .ld_addr_in      (ld_addr_in),
    .ld_data_in      (ld_data_in),
    .ld_valid_in     (ld_valid_in),
    .cpu_req_in      (cpu_req_in),
    .cpu_addr_in     (cpu_addr_in),
    .cpu_data_in     (cpu_data_in),
    .cpu_we_in       (cpu_we_in),
    .cpu_stall_out   (cpu_stall_out),
    .mem_addr_out    (mem_addr_out),
    .mem_data_out    (mem_data_out),
    .mem_we_out      (mem_we_out),
    .ld_busy_out     (ld_busy_out),
    .ld_overflow_out (ld_overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n_in    = 1'b0;
    ld_addr_in  = '0;
    ld_data_in  = '0;
    ld_valid_in = 1'b0;
    cpu_req_in  = 1'b0;
    cpu_addr_in = '0;
    cpu_data_in = '0;
    cpu_we_in   = '0;
    #2;
    check_eq("rst_addr", mem_addr_out, 0);
    check_eq("rst_data", mem_data_out, 0);
    check_eq("rst_we", mem_we_out, 0);
    check_eq("rst_busy", ld_busy_out, 0);
    check_eq("rst_ovf", ld_overflow_out, 0);
    check_eq("rst_stall", cpu_stall_out, 0);
    #10 rst_n_in = 1'b1;
    tick();
    tick();

    // Single loader write with idle CPU.
    ld_valid_in = 1'b1;
    ld_addr_in  = 32'h0000_0010;
    ld_data_in  = 32'hDEAD_BEEF;
    tick();
    ld_valid_in = 1'b0;
    check_eq("idle_nobypass_we", mem_we_out, 4'b0000);
    check_eq("idle_busy_queued", ld_busy_out, 1);
    tick();
    check_eq("idle_addr", mem_addr_out, 12'h004);
    check_eq("idle_data", mem_data_out, 32'hDEAD_BEEF);
    check_eq("idle_we", mem_we_out, 4'b1111);
    check_eq("idle_busy_grant", ld_busy_out, 1);
    tick();
    check_eq("idle_we_after", mem_we_out, 4'b0000);
    check_eq("idle_busy_fall", ld_busy_out, 0);
    check_eq("idle_addr_hold", mem_addr_out, 12'h004);

    // CPU priority with starvation relief after 8 grants.
    cpu_req_in  = 1'b1;
    cpu_addr_in = 32'h0002_0008;
    cpu_data_in = 32'h1234_5678;
    cpu_we_in   = 4'b0011;
    ld_valid_in = 1'b1;
    ld_addr_in  = 32'h0000_0040;
    ld_data_in  = 32'hA5A5_A5A5;
    #1;
    check_eq("stv_c0_stall", cpu_stall_out, 0);
    tick();
    ld_valid_in = 1'b0;
    check_eq("stv_c0_we", mem_we_out, 4'b0011);
    for (int i = 1; i <= 8; i++) begin
      check_eq("stv_cpu_stall", cpu_stall_out, 0);
      tick();
      check_eq("stv_cpu_addr", mem_addr_out, 12'h002);
      check_eq("stv_cpu_we", mem_we_out, 4'b0011);
    end
    check_eq("stv_c9_stall", cpu_stall_out, 1);
    tick();
    check_eq("stv_ld_addr", mem_addr_out, 12'h010);
    check_eq("stv_ld_data", mem_data_out, 32'hA5A5_A5A5);
    check_eq("stv_ld_we", mem_we_out, 4'b1111);
    check_eq("stv_c10_stall", cpu_stall_out, 0);
    tick();
    check_eq("stv_c10_we", mem_we_out, 4'b0011);
    check_eq("stv_c10_data", mem_data_out, 32'h1234_5678);
    cpu_req_in = 1'b0;
    tick();
    check_eq("stv_idle_we", mem_we_out, 4'b0000);

    // Out-of-range CPU write is granted but masked.
    cpu_req_in  = 1'b1;
    cpu_addr_in = 32'h0001_0004;
    cpu_data_in = 32'hCAFE_F00D;
    cpu_we_in   = 4'b1111;
    #1;
    check_eq("rng_stall", cpu_stall_out, 0);
    tick();
    check_eq("rng_addr", mem_addr_out, 12'h001);
    check_eq("rng_we", mem_we_out, 4'b0000);
    check_eq("rng_data", mem_data_out, 32'hCAFE_F00D);
    cpu_req_in = 1'b0;
    tick();

    // Overflow: five pulses into a four-deep FIFO while the CPU holds the port.
    cpu_req_in  = 1'b1;
    cpu_addr_in = 32'h0002_0000;
    cpu_data_in = 32'h0;
    cpu_we_in   = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      ld_valid_in = 1'b1;
      ld_addr_in  = 32'h100 + 32'(4 * i);
      ld_data_in  = 32'h1000_0000 + 32'(i);
      #1;
      check_eq("ovf_stall", cpu_stall_out, 0);
      check_eq("ovf_pre", ld_overflow_out, 0);
      tick();
    end
    ld_valid_in = 1'b0;
    check_eq("ovf_set", ld_overflow_out, 1);
    cpu_req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("ovf_drain_addr", mem_addr_out, 12'h040 + 12'(i));
      check_eq("ovf_drain_data", mem_data_out, 32'h1000_0000 + 32'(i));
      check_eq("ovf_drain_we", mem_we_out, 4'b1111);
    end
    tick();
    check_eq("ovf_no_5th", mem_we_out, 4'b0000);
    check_eq("ovf_busy_fall", ld_busy_out, 0);
    check_eq("ovf_sticky", ld_overflow_out, 1);

    // Asynchronous reset mid-cycle with three queued entries.
    cpu_req_in  = 1'b1;
    cpu_addr_in = 32'h0002_0010;
    cpu_data_in = 32'h0000_0055;
    cpu_we_in   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      ld_valid_in = 1'b1;
      ld_addr_in  = 32'h300 + 32'(4 * i);
      ld_data_in  = 32'h3000_0000 + 32'(i);
      tick();
    end
    ld_valid_in = 1'b0;
    check_eq("pre_rst_we", mem_we_out, 4'b1111);
    check_eq("pre_rst_busy", ld_busy_out, 1);
    #3 rst_n_in = 1'b0;
    #1;
    check_eq("arst_addr", mem_addr_out, 0);
    check_eq("arst_data", mem_data_out, 0);
    check_eq("arst_we", mem_we_out, 0);
    check_eq("arst_busy", ld_busy_out, 0);
    check_eq("arst_ovf", ld_overflow_out, 0);
    check_eq("arst_stall", cpu_stall_out, 0);
    #2;
    cpu_req_in = 1'b0;
    rst_n_in   = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_we_out != 4'b0000 || ld_busy_out) seen++;
    end
    check_eq("arst_queue_flushed", seen, 0);

    // Full FIFO with a simultaneous pop accepts the new pulse.
    cpu_req_in  = 1'b1;
    cpu_addr_in = 32'h0002_0000;
    cpu_data_in = 32'h0;
    cpu_we_in   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ld_valid_in = 1'b1;
      ld_addr_in  = 32'h200 + 32'(4 * i);
      ld_data_in  = 32'h2000_0000 + 32'(i);
      tick();
    end
    cpu_req_in  = 1'b0;
    ld_valid_in = 1'b1;
    ld_addr_in  = 32'h210;
    ld_data_in  = 32'h2000_0004;
    tick();
    ld_valid_in = 1'b0;
    check_eq("fp_ovf", ld_overflow_out, 0);
    check_eq("fp_addr0", mem_addr_out, 12'h080);
    check_eq("fp_data0", mem_data_out, 32'h2000_0000);
    check_eq("fp_we0", mem_we_out, 4'b1111);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("fp_addr", mem_addr_out, 12'h080 + 12'(i));
      check_eq("fp_data", mem_data_out, 32'h2000_0000 + 32'(i));
      check_eq("fp_we", mem_we_out, 4'b1111);
      check_eq("fp_busy", ld_busy_out, 1);
    end
    tick();
    check_eq("fp_we_end", mem_we_out, 4'b0000);
    check_eq("fp_busy_end", ld_busy_out, 0);
    check_eq("fp_ovf_end", ld_overflow_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
